// File: rtl/usb_pkg.sv
// Shared constants and state encoding for the ULPI PHY-side receive driver.
package usb_pkg;

  localparam int          MAX_BYTES    = 66;
  localparam int          PKT_WIDTH    = 528;
  localparam logic [7:0]  RXCMD_ACTIVE = 8'h10;
  localparam logic [7:0]  RXCMD_IDLE   = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    TURN_ON,
    RXCMD_START,
    DATA,
    RXCMD_END,
    TURN_OFF
  } ulpi_rx_state_t;

endpackage

// File: rtl/ulpi_rx_shift.sv
// Packet byte store: loads a whole packet and shifts it out top byte first.
module ulpi_rx_shift (
  input  logic                          ulpi_clk,
  input  logic                          n_rst,
  input  logic                          load,
  input  logic                          shift,
  input  logic [usb_pkg::PKT_WIDTH-1:0] load_data,
  output logic [7:0]                    top_byte
);
  import usb_pkg::*;

  logic [PKT_WIDTH-1:0] shift_q;
  logic [PKT_WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = load_data;
    end else if (shift) begin
      shift_d = {shift_q[PKT_WIDTH-9:0], 8'h00};
    end
  end

  always_ff @(posedge ulpi_clk) begin
    if (!n_rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign top_byte = shift_q[PKT_WIDTH-1 -: 8];

endmodule

// File: rtl/ulpi_phy_rx_driver.sv
// PHY side of the ULPI receive path: claims the bus, sends RX CMDs and packet
// bytes qualified by nxt, then hands the bus back to the link.
module ulpi_phy_rx_driver #(
  parameter int         MAX_BYTES    = usb_pkg::MAX_BYTES,
  parameter logic [7:0] RXCMD_ACTIVE = usb_pkg::RXCMD_ACTIVE,
  parameter logic [7:0] RXCMD_IDLE   = usb_pkg::RXCMD_IDLE
) (
  input  logic                          ulpi_clk,
  input  logic                          n_rst,
  input  logic                          pkt_valid,
  input  logic [usb_pkg::PKT_WIDTH-1:0] pkt_data,
  input  logic [6:0]                    pkt_len,
  output logic                          pkt_ready,
  input  logic                          stall,
  input  logic [7:0]                    link_data,
  output logic                          dir,
  output logic                          nxt,
  output logic [7:0]                    data_out,
  output logic                          busy,
  output logic                          done
);
  import usb_pkg::*;

  localparam logic [6:0] MAX_LEN = 7'(MAX_BYTES);

  ulpi_rx_state_t state_q, state_d;
  logic [6:0] len_q, len_d;
  logic [6:0] count_q, count_d;
  logic       dir_q, dir_d;
  logic       nxt_q, nxt_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic       load;
  logic       shift;
  logic [7:0] top_byte;

  ulpi_rx_shift u_shift (
    .ulpi_clk  (ulpi_clk),
    .n_rst     (n_rst),
    .load      (load),
    .shift     (shift),
    .load_data (pkt_data),
    .top_byte  (top_byte)
  );

  // Outputs are derived from the next state so they appear registered in the
  // same cycle the state does; stall therefore shapes the DATA cycle it enters.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    load    = 1'b0;
    shift   = 1'b0;
    dir_d   = 1'b0;
    nxt_d   = 1'b0;
    data_d  = 8'h00;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pkt_valid && ready_q) begin
          state_d = TURN_ON;
          load    = 1'b1;
          len_d   = (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
          count_d = '0;
        end
      end
      TURN_ON:     state_d = RXCMD_START;
      RXCMD_START: state_d = (len_q != '0) ? DATA : RXCMD_END;
      DATA:        if (count_q == len_q) state_d = RXCMD_END;
      RXCMD_END:   state_d = TURN_OFF;
      TURN_OFF:    state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    case (state_d)
      IDLE: ready_d = (link_data == 8'h00);
      TURN_ON: begin
        dir_d  = 1'b1;
        busy_d = 1'b1;
        data_d = RXCMD_IDLE;
      end
      RXCMD_START: begin
        dir_d  = 1'b1;
        busy_d = 1'b1;
        data_d = RXCMD_ACTIVE;
      end
      DATA: begin
        dir_d  = 1'b1;
        busy_d = 1'b1;
        if (stall) begin
          data_d = RXCMD_ACTIVE;
        end else begin
          nxt_d   = 1'b1;
          data_d  = top_byte;
          shift   = 1'b1;
          count_d = count_q + 7'd1;
        end
      end
      RXCMD_END: begin
        dir_d  = 1'b1;
        busy_d = 1'b1;
        data_d = RXCMD_IDLE;
      end
      TURN_OFF: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ulpi_clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      nxt_q   <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      nxt_q   <= nxt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign pkt_ready = ready_q;
  assign dir       = dir_q;
  assign nxt       = nxt_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ulpi_phy_rx_driver.sv
// Directed bench for ulpi_phy_rx_driver: per-cycle vector table plus long-packet
// stall and mid-packet reset sequences.
module tb_ulpi_phy_rx_driver;

  logic         ulpi_clk = 1'b0;
  logic         n_rst;
  logic         pkt_valid;
  logic [527:0] pkt_data;
  logic [6:0]   pkt_len;
  logic         pkt_ready;
  logic         stall;
  logic [7:0]   link_data;
  logic         dir;
  logic         nxt;
  logic [7:0]   data_out;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ulpi_clk = ~ulpi_clk;

  ulpi_phy_rx_driver dut (
    .ulpi_clk  (ulpi_clk),
    .n_rst     (n_rst),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data),
    .pkt_len   (pkt_len),
    .pkt_ready (pkt_ready),
    .stall     (stall),
    .link_data (link_data),
    .dir       (dir),
    .nxt       (nxt),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [6:0] len;
    logic [7:0] link;
    logic       stl;
    logic [7:0] b_even;
    logic [7:0] b_odd;
    logic       e_dir;
    logic       e_nxt;
    logic [7:0] e_data;
    logic       e_busy;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  vec_t vecs[26];

  function automatic logic [527:0] make_pkt(input logic [7:0] be, input logic [7:0] bo);
    logic [527:0] p;
    p = '0;
    for (int k = 0; k < 66; k++) p[527-8*k -: 8] = (k % 2 == 1) ? bo : be;
    return p;
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [6:0] l,
                              input logic [7:0] lk, input logic s, input logic [7:0] be,
                              input logic [7:0] bo, input logic ed, input logic en,
                              input logic [7:0] edt, input logic eb, input logic edn,
                              input logic er);
    vec_t t;
    t.rst_n = r;  t.valid = v;  t.len = l;  t.link = lk;  t.stl = s;
    t.b_even = be; t.b_odd = bo;
    t.e_dir = ed; t.e_nxt = en; t.e_data = edt; t.e_busy = eb; t.e_done = edn; t.e_ready = er;
    return t;
  endfunction

  task automatic tick();
    @(posedge ulpi_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    n_rst     = v.rst_n;
    pkt_valid = v.valid;
    pkt_len   = v.len;
    link_data = v.link;
    stall     = v.stl;
    pkt_data  = make_pkt(v.b_even, v.b_odd);
    tick();
  endtask

  task automatic waitReady(input string name);
    for (int i = 0; i < 10 && pkt_ready !== 1'b1; i++) tick();
    checkOutput(name, 32'(pkt_ready), 32'd1);
  endtask

  int cyc, dir_cycles, nxt_cnt, done_cyc;
  logic stalled, expect_stall;

  initial begin
    n_rst = 1'b0; pkt_valid = 1'b0; pkt_len = '0; link_data = 8'h00; stall = 1'b0;
    pkt_data = '0;

    //            rst valid len  link  stl  be     bo     dir nxt data  busy done rdy
    vecs[0]  = mk(0, 1, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 0, 0, 8'h00, 0, 0, 0);
    vecs[1]  = mk(0, 1, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 0, 0, 8'h00, 0, 0, 0);
    vecs[2]  = mk(1, 1, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 0, 0, 8'h00, 0, 0, 1);
    vecs[3]  = mk(1, 1, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 1, 0, 8'h00, 1, 0, 0);
    vecs[4]  = mk(1, 0, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 1, 0, 8'h10, 1, 0, 0);
    vecs[5]  = mk(1, 0, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 1, 1, 8'hAA, 1, 0, 0);
    vecs[6]  = mk(1, 0, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 1, 1, 8'hBB, 1, 0, 0);
    vecs[7]  = mk(1, 0, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 1, 0, 8'h00, 1, 0, 0);
    vecs[8]  = mk(1, 0, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 0, 0, 8'h00, 1, 1, 0);
    vecs[9]  = mk(1, 0, 7'd2, 8'h00, 0, 8'hAA, 8'hBB, 0, 0, 8'h00, 0, 0, 1);
    vecs[10] = mk(1, 1, 7'd0, 8'h00, 0, 8'hAA, 8'hBB, 1, 0, 8'h00, 1, 0, 0);
    vecs[11] = mk(1, 0, 7'd0, 8'h00, 0, 8'hAA, 8'hBB, 1, 0, 8'h10, 1, 0, 0);
    vecs[12] = mk(1, 0, 7'd0, 8'h00, 0, 8'hAA, 8'hBB, 1, 0, 8'h00, 1, 0, 0);
    vecs[13] = mk(1, 0, 7'd0, 8'h00, 0, 8'hAA, 8'hBB, 0, 0, 8'h00, 1, 1, 0);
    vecs[14] = mk(1, 0, 7'd0, 8'h00, 0, 8'hAA, 8'hBB, 0, 0, 8'h00, 0, 0, 1);
    vecs[15] = mk(1, 0, 7'd1, 8'h40, 0, 8'h5A, 8'h5A, 0, 0, 8'h00, 0, 0, 0);
    vecs[16] = mk(1, 1, 7'd1, 8'h40, 0, 8'h5A, 8'h5A, 0, 0, 8'h00, 0, 0, 0);
    vecs[17] = mk(1, 1, 7'd1, 8'h40, 0, 8'h5A, 8'h5A, 0, 0, 8'h00, 0, 0, 0);
    vecs[18] = mk(1, 1, 7'd1, 8'h00, 0, 8'h5A, 8'h5A, 0, 0, 8'h00, 0, 0, 1);
    vecs[19] = mk(1, 1, 7'd1, 8'h00, 0, 8'h5A, 8'h5A, 1, 0, 8'h00, 1, 0, 0);
    vecs[20] = mk(1, 0, 7'd1, 8'h00, 1, 8'h5A, 8'h5A, 1, 0, 8'h10, 1, 0, 0);
    vecs[21] = mk(1, 0, 7'd1, 8'h00, 1, 8'h5A, 8'h5A, 1, 0, 8'h10, 1, 0, 0);
    vecs[22] = mk(1, 0, 7'd1, 8'h00, 0, 8'h5A, 8'h5A, 1, 1, 8'h5A, 1, 0, 0);
    vecs[23] = mk(1, 0, 7'd1, 8'h00, 1, 8'h5A, 8'h5A, 1, 0, 8'h00, 1, 0, 0);
    vecs[24] = mk(1, 0, 7'd1, 8'h00, 0, 8'h5A, 8'h5A, 0, 0, 8'h00, 1, 1, 0);
    vecs[25] = mk(1, 0, 7'd1, 8'h00, 0, 8'h5A, 8'h5A, 0, 0, 8'h00, 0, 0, 1);

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d dir", i),   32'(dir),       32'(vecs[i].e_dir));
      checkOutput($sformatf("v%0d nxt", i),   32'(nxt),       32'(vecs[i].e_nxt));
      checkOutput($sformatf("v%0d data", i),  32'(data_out),  32'(vecs[i].e_data));
      checkOutput($sformatf("v%0d busy", i),  32'(busy),      32'(vecs[i].e_busy));
      checkOutput($sformatf("v%0d done", i),  32'(done),      32'(vecs[i].e_done));
      checkOutput($sformatf("v%0d ready", i), 32'(pkt_ready), 32'(vecs[i].e_ready));
    end
    stall = 1'b0;

    // Long packet: length 100 clamps to 66, one stall after the tenth byte.
    waitReady("ready before long pkt");
    pkt_valid = 1'b1; pkt_len = 7'd100; pkt_data = make_pkt(8'hAA, 8'hBB);
    tick();
    pkt_valid = 1'b0;
    checkOutput("long accept dir", 32'(dir), 32'd1);
    cyc = 1; dir_cycles = 0; nxt_cnt = 0; done_cyc = 0; stalled = 1'b0; expect_stall = 1'b0;
    for (int i = 0; i < 200 && done_cyc == 0; i++) begin
      if (expect_stall) begin
        checkOutput("stall cycle", {22'd0, dir, nxt, data_out}, {22'd0, 1'b1, 1'b0, 8'h10});
        expect_stall = 1'b0;
      end
      if (dir) dir_cycles++;
      if (nxt) begin
        checkOutput($sformatf("long byte %0d", nxt_cnt), 32'(data_out),
                    (nxt_cnt % 2 == 1) ? 32'hBB : 32'hAA);
        nxt_cnt++;
      end
      if (done) done_cyc = cyc;
      if (nxt_cnt == 10 && !stalled) begin
        stall = 1'b1; stalled = 1'b1; expect_stall = 1'b1;
      end
      if (done_cyc == 0) begin
        tick();
        cyc++;
        stall = 1'b0;
      end
    end
    checkOutput("long nxt pulses", 32'(nxt_cnt), 32'd66);
    checkOutput("long dir cycles", 32'(dir_cycles), 32'd70);
    checkOutput("long done cycle", 32'(done_cyc), 32'd71);

    // Reset while byte 5 of a 20-byte packet is on the bus.
    tick();
    waitReady("ready before 20-byte pkt");
    pkt_valid = 1'b1; pkt_len = 7'd20; pkt_data = make_pkt(8'h11, 8'h22);
    tick();
    pkt_valid = 1'b0;
    nxt_cnt = 0;
    for (int i = 0; i < 40 && nxt_cnt < 5; i++) begin
      tick();
      if (nxt) nxt_cnt++;
    end
    checkOutput("pulses before reset", 32'(nxt_cnt), 32'd5);
    n_rst = 1'b0;
    tick();
    checkOutput("abort dir", 32'(dir), 32'd0);
    checkOutput("abort nxt", 32'(nxt), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort data", 32'(data_out), 32'd0);
    n_rst = 1'b1;
    waitReady("ready after abort");
    pkt_valid = 1'b1; pkt_len = 7'd1; pkt_data = make_pkt(8'hC3, 8'h3C);
    tick();
    pkt_valid = 1'b0;
    checkOutput("post-abort accept dir", 32'(dir), 32'd1);
    tick();
    tick();
    checkOutput("post-abort byte", {22'd0, dir, nxt, data_out}, {22'd0, 1'b1, 1'b1, 8'hC3});
    tick();
    tick();
    checkOutput("post-abort done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
